// File: rtl/csr_file_m.sv
// Machine-mode CSR file and trap controller for the rvcore pipeline.
// Optional feature: define CSR_VECTORED_MODE_EN to enable vectored interrupt mode in mtvec.
module csr_file_m #(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int          CNT_WIDTH     = 64,
    parameter logic [31:0] HART_ID       = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     csr_valid,
    input  logic [1:0]               csr_op,
    input  logic                     csr_src_zero,
    input  logic [11:0]              csr_addr,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    input  logic                     instr_retire,
    input  logic                     mret,
    input  logic                     exc_valid,
    input  logic [4:0]               exc_cause,
    input  logic [31:0]              exc_tval,
    input  logic [31:0]              pc,
    input  logic                     irq_ext,
    input  logic                     irq_timer,
    input  logic                     irq_soft,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    output logic                     trap_taken,
    output logic                     redirect,
    output logic [31:0]              redirect_pc
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888 |
                                       (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_mstatus_mie;
    logic                 r_mstatus_mpie;
    logic [31:0]          r_mie;
    logic [31:0]          r_mip;
    logic [31:2]          r_mtvec_base;
    logic [1:0]           w_mtvec_mode;
    logic [31:0]          r_mscratch;
    logic [31:2]          r_mepc;
    logic [31:0]          r_mcause;
    logic [31:0]          r_mtval;
    logic [CNT_WIDTH-1:0] r_mcycle;
    logic [CNT_WIDTH-1:0] r_minstret;

    logic [63:0]          w_cycle64;
    logic [63:0]          w_instret64;
    logic [31:0]          w_rdata;
    logic                 w_impl;
    logic                 w_ro;
    logic                 w_op_act;
    logic                 w_wr_try;
    logic                 w_wen;
    logic [31:0]          w_wval;
    logic [31:0]          w_mip_in;
    logic [31:0]          w_pend;
    logic [4:0]           w_int_cause;
    logic                 w_int_take;
    logic                 w_trap;
    logic                 w_is_irq;
    logic [4:0]           w_cause;
    logic [31:0]          w_tvec_base;
    logic                 w_unused;

    assign w_unused    = &{1'b0, pc[1:0]};
    assign w_cycle64   = 64'(r_mcycle);
    assign w_instret64 = 64'(r_minstret);

    // Read mux; w_impl flags implemented addresses, misa and mip are the RO ones outside the 11xx range.
    always_comb begin
        w_rdata = 32'h0;
        w_impl  = 1'b1;
        w_ro    = (csr_addr[11:10] == 2'b11);
        case (csr_addr)
            A_MSTATUS:              w_rdata = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            A_MISA:    begin        w_rdata = 32'h4000_0100; w_ro = 1'b1; end
            A_MHARTID:              w_rdata = HART_ID;
            A_MIE:                  w_rdata = r_mie;
            A_MIP:     begin        w_rdata = r_mip; w_ro = 1'b1; end
            A_MTVEC:                w_rdata = {r_mtvec_base, w_mtvec_mode};
            A_MSCRATCH:             w_rdata = r_mscratch;
            A_MEPC:                 w_rdata = {r_mepc, 2'b00};
            A_MCAUSE:               w_rdata = r_mcause;
            A_MTVAL:                w_rdata = r_mtval;
            A_MCYCLE, A_CYCLE:      w_rdata = w_cycle64[31:0];
            A_MCYCLEH, A_CYCLEH:    w_rdata = w_cycle64[63:32];
            A_MINSTRET, A_INSTRET:  w_rdata = w_instret64[31:0];
            A_MINSTRETH, A_INSTRETH: w_rdata = w_instret64[63:32];
            default:                w_impl  = 1'b0;
        endcase
    end

    assign csr_rdata   = w_rdata;
    assign w_op_act    = csr_valid & (csr_op != 2'b00);
    assign w_wr_try    = w_op_act & ~((csr_op != 2'b01) & csr_src_zero);
    assign csr_illegal = w_op_act & (~w_impl | (w_wr_try & w_ro));
    assign w_wen       = w_wr_try & ~csr_illegal & ~w_trap;

    always_comb begin
        case (csr_op)
            2'b10:   w_wval = w_rdata | csr_wdata;
            2'b11:   w_wval = w_rdata & ~csr_wdata;
            default: w_wval = csr_wdata;
        endcase
    end

    always_comb begin
        w_mip_in = 32'h0;
        w_mip_in[3]  = irq_soft;
        w_mip_in[7]  = irq_timer;
        w_mip_in[11] = irq_ext;
        w_mip_in[16 +: NUM_LOCAL_IRQ] = irq_local;
    end

    // Priority MEI > MSI > MTI > local; the descending loop lets the lowest local index win.
    always_comb begin
        w_pend      = r_mip & r_mie;
        w_int_cause = 5'd0;
        if (w_pend[11])
            w_int_cause = 5'd11;
        else if (w_pend[3])
            w_int_cause = 5'd3;
        else if (w_pend[7])
            w_int_cause = 5'd7;
        else
            for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
                if (w_pend[16 + i])
                    w_int_cause = 5'(16 + i);
    end

    assign w_int_take  = r_mstatus_mie & (|w_pend);
    assign w_trap      = exc_valid | w_int_take;
    assign w_is_irq    = ~exc_valid & w_int_take;
    assign w_cause     = exc_valid ? exc_cause : w_int_cause;
    assign trap_taken  = w_trap;
    assign redirect    = w_trap | mret;
    assign w_tvec_base = {r_mtvec_base, 2'b00};

    always_comb begin
        redirect_pc = 32'h0;
        if (w_trap) begin
            if ((w_mtvec_mode == 2'b01) && w_is_irq)
                redirect_pc = w_tvec_base + {25'b0, w_int_cause, 2'b00};
            else
                redirect_pc = w_tvec_base;
        end else if (mret) begin
            redirect_pc = {r_mepc, 2'b00};
        end
    end

`ifdef CSR_VECTORED_MODE_EN
    logic [1:0] r_mtvec_mode;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_mtvec_mode <= (MTVEC_RESET[1:0] == 2'b01) ? 2'b01 : 2'b00;
        else if (w_wen && (csr_addr == A_MTVEC))
            r_mtvec_mode <= (w_wval[1:0] == 2'b01) ? 2'b01 : 2'b00;
    end
    assign w_mtvec_mode = r_mtvec_mode;
`else
    assign w_mtvec_mode = 2'b00;
`endif

    // Trap entry overrides mret, which overrides a software write to mstatus.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0;
            r_mip          <= 32'h0;
            r_mtvec_base   <= MTVEC_RESET[31:2];
            r_mscratch     <= 32'h0;
            r_mepc         <= 30'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
        end else begin
            r_mip <= w_mip_in;
            if (w_trap) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= pc[31:2];
                r_mcause       <= {w_is_irq, 26'b0, w_cause};
                r_mtval        <= w_is_irq ? 32'h0 : exc_tval;
            end else if (mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wen) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        r_mstatus_mie  <= w_wval[3];
                        r_mstatus_mpie <= w_wval[7];
                    end
                    A_MIE:      r_mie        <= w_wval & IRQ_MASK;
                    A_MTVEC:    r_mtvec_base <= w_wval[31:2];
                    A_MSCRATCH: r_mscratch   <= w_wval;
                    A_MEPC:     r_mepc       <= w_wval[31:2];
                    A_MCAUSE:   r_mcause     <= w_wval;
                    A_MTVAL:    r_mtval      <= w_wval;
                    default: ;
                endcase
            end
        end
    end

    // A write to one half replaces that half and suppresses the increment for the cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wen && (csr_addr == A_MCYCLE))
                r_mcycle[31:0] <= w_wval;
            else if (w_wen && (csr_addr == A_MCYCLEH))
                r_mcycle[CNT_WIDTH-1:32] <= w_wval[CNT_WIDTH-33:0];
            else
                r_mcycle <= r_mcycle + CNT_ONE;

            if (w_wen && (csr_addr == A_MINSTRET))
                r_minstret[31:0] <= w_wval;
            else if (w_wen && (csr_addr == A_MINSTRETH))
                r_minstret[CNT_WIDTH-1:32] <= w_wval[CNT_WIDTH-33:0];
            else if (instr_retire)
                r_minstret <= r_minstret + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: the driver queues cycle-stamped expectations, a negedge monitor checks them.
module tb_csr_file_m;

    localparam logic [31:0] MTV_RST = 32'h0000_0200;
    localparam logic [11:0] MSTATUS = 12'h300, MISA = 12'h301, MIE = 12'h304, MTVEC = 12'h305;
    localparam logic [11:0] MSCRATCH = 12'h340, MEPC = 12'h341, MCAUSE = 12'h342, MTVAL = 12'h343;
    localparam logic [11:0] MIP = 12'h344, MCYCLE = 12'hB00, MINSTRET = 12'hB02, MCYCLEH = 12'hB80;
    localparam logic [11:0] CYCLE = 12'hC00, INSTRET = 12'hC02, CYCLEH = 12'hC80, MHARTID = 12'hF14;
    localparam int S_RD = 0, S_ILL = 1, S_TRAP = 2, S_RED = 3, S_RPC = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        csr_valid, csr_src_zero, instr_retire, mret, exc_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, exc_tval, pc;
    logic [4:0]  exc_cause;
    logic        irq_ext, irq_timer, irq_soft;
    logic [3:0]  irq_local;
    logic [31:0] csr_rdata, redirect_pc;
    logic        csr_illegal, trap_taken, redirect;

    always #5 clock = ~clock;

    csr_file_m #(
        .NUM_LOCAL_IRQ(4), .CNT_WIDTH(40), .HART_ID(32'd3), .MTVEC_RESET(MTV_RST)
    ) dut (
        .clock(clock), .reset_n(reset_n), .csr_valid(csr_valid), .csr_op(csr_op),
        .csr_src_zero(csr_src_zero), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instr_retire(instr_retire),
        .mret(mret), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .pc(pc), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .irq_local(irq_local), .trap_taken(trap_taken), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void expect_val(string name, int sel, logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            case (mon_e.sel)
                S_RD:    mon_act = csr_rdata;
                S_ILL:   mon_act = {31'b0, csr_illegal};
                S_TRAP:  mon_act = {31'b0, trap_taken};
                S_RED:   mon_act = {31'b0, redirect};
                default: mon_act = redirect_pc;
            endcase
            n_cmp++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
                n_err++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", mon_e.name, cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic idle();
        csr_valid = 1'b0; csr_op = 2'b00; csr_src_zero = 1'b0; csr_addr = 12'h0;
        csr_wdata = 32'h0; instr_retire = 1'b0; mret = 1'b0; exc_valid = 1'b0;
        exc_cause = 5'd0; exc_tval = 32'h0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d, input logic z);
        csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d; csr_src_zero = z;
    endtask

    task automatic rd(input logic [11:0] a);
        csr(2'b10, a, 32'h0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; irq_local = 4'h0; pc = 32'h0;
        idle();
        step();
        expect_val("rst_trap", S_TRAP, 32'd0);
        expect_val("rst_redirect", S_RED, 32'd0);
        expect_val("rst_redirect_pc", S_RPC, 32'd0);
        step(); reset_n = 1'b1; rd(MSTATUS);
        expect_val("rst_mstatus", S_RD, 32'h0000_1800);
        expect_val("rst_rd_illegal", S_ILL, 32'd0);
        step(); rd(MTVEC);   expect_val("rst_mtvec", S_RD, MTV_RST);
        step(); rd(MHARTID); expect_val("mhartid", S_RD, 32'd3);
        step(); rd(MISA);    expect_val("misa", S_RD, 32'h4000_0100);

        // Illegal accesses
        step(); csr(2'b01, MHARTID, 32'd5, 1'b0); expect_val("wr_ro_illegal", S_ILL, 32'd1);
        step(); csr(2'b10, CYCLE, 32'd0, 1'b1);   expect_val("rs_zero_ro_legal", S_ILL, 32'd0);
        step(); rd(12'h7C0);                      expect_val("unimpl_illegal", S_ILL, 32'd1);
        step(); rd(MHARTID);                      expect_val("mhartid_unchanged", S_RD, 32'd3);

        // RW / RS / RC on mscratch
        step(); csr(2'b01, MSCRATCH, 32'hA5A5_0000, 1'b0); expect_val("rw_old", S_RD, 32'h0);
        step(); csr(2'b10, MSCRATCH, 32'h0000_000F, 1'b0); expect_val("rs_old", S_RD, 32'hA5A5_0000);
        step(); csr(2'b11, MSCRATCH, 32'hA000_0000, 1'b0); expect_val("rc_old", S_RD, 32'hA5A5_000F);
        step(); rd(MSCRATCH);                              expect_val("rc_result", S_RD, 32'h05A5_000F);

        // Timer interrupt entry and mret
        step(); csr(2'b01, MIE, 32'h0000_0080, 1'b0);     expect_val("mie_old", S_RD, 32'h0);
        step(); csr(2'b10, MSTATUS, 32'h0000_0008, 1'b0); expect_val("mstatus_pre", S_RD, 32'h1800);
        step(); irq_timer = 1'b1; pc = 32'h100;           expect_val("irq_latency", S_TRAP, 32'd0);
        step();
        expect_val("irq_trap", S_TRAP, 32'd1);
        expect_val("irq_redirect", S_RED, 32'd1);
        expect_val("irq_rpc", S_RPC, MTV_RST);
        step(); irq_timer = 1'b0; rd(MCAUSE);
        expect_val("irq_mcause", S_RD, 32'h8000_0007);
        expect_val("irq_masked", S_TRAP, 32'd0);
        step(); rd(MEPC);    expect_val("irq_mepc", S_RD, 32'h100);
        step(); rd(MSTATUS); expect_val("irq_mstatus", S_RD, 32'h1880);
        step(); mret = 1'b1;
        expect_val("mret_redirect", S_RED, 32'd1);
        expect_val("mret_rpc", S_RPC, 32'h100);
        expect_val("mret_no_trap", S_TRAP, 32'd0);
        step(); rd(MSTATUS); expect_val("mret_mstatus", S_RD, 32'h1888);
        step(); rd(MTVAL);   expect_val("irq_mtval", S_RD, 32'h0);
        step(); csr(2'b11, MIE, 32'h0000_0080, 1'b0); expect_val("mie_clr_old", S_RD, 32'h80);

        // Exception beats a pending external interrupt and drops the CSR write
        step(); csr(2'b01, MIE, 32'h0000_0800, 1'b0); irq_ext = 1'b1; pc = 32'h300;
        step(); exc_valid = 1'b1; exc_cause = 5'd5; exc_tval = 32'hDEAD_BEEF;
        csr(2'b01, MSCRATCH, 32'h0000_1234, 1'b0);
        expect_val("exc_trap", S_TRAP, 32'd1);
        expect_val("exc_rpc", S_RPC, MTV_RST);
        step(); irq_ext = 1'b0; rd(MCAUSE); expect_val("exc_mcause", S_RD, 32'd5);
        step(); rd(MTVAL);    expect_val("exc_mtval", S_RD, 32'hDEAD_BEEF);
        step(); rd(MSCRATCH); expect_val("exc_mscratch", S_RD, 32'h05A5_000F);
        step(); rd(MEPC);     expect_val("exc_mepc", S_RD, 32'h300);
        step(); csr(2'b01, MIE, 32'h0, 1'b0);

        // Counters (CNT_WIDTH = 40)
        step(); csr(2'b01, MCYCLEH, 32'h0, 1'b0);
        step(); csr(2'b01, MCYCLE, 32'hFFFF_FFFF, 1'b0);
        step(); rd(MCYCLE);  expect_val("mcycle_pre", S_RD, 32'hFFFF_FFFF);
        step(); rd(MCYCLE);  expect_val("mcycle_carry_lo", S_RD, 32'h0);
        step(); rd(MCYCLEH); expect_val("mcycle_carry_hi", S_RD, 32'h1);
        step(); csr(2'b01, MCYCLEH, 32'hFFFF_FFFF, 1'b0);
        step(); csr(2'b01, MCYCLE, 32'hFFFF_FFFF, 1'b0);
        step(); rd(MCYCLEH); expect_val("mcycleh_width", S_RD, 32'h0000_00FF);
        step(); rd(MCYCLE);  expect_val("mcycle_wrap_lo", S_RD, 32'h0);
        step(); rd(CYCLEH);  expect_val("cycleh_wrap", S_RD, 32'h0);
        step(); csr(2'b01, MINSTRET, 32'd10, 1'b0); instr_retire = 1'b1;
        expect_val("minstret_old", S_RD, 32'h0);
        step(); rd(MINSTRET); instr_retire = 1'b1; expect_val("minstret_wr_wins", S_RD, 32'd10);
        step(); rd(INSTRET);  expect_val("instret_inc", S_RD, 32'd11);
        step(); rd(MINSTRET); expect_val("minstret_hold", S_RD, 32'd11);

        // Local interrupt, vectored if enabled
        step(); csr(2'b01, MTVEC, 32'h0000_1001, 1'b0); expect_val("mtvec_old", S_RD, MTV_RST);
        step(); rd(MTVEC);
`ifdef CSR_VECTORED_MODE_EN
        expect_val("mtvec_mode", S_RD, 32'h1001);
`else
        expect_val("mtvec_mode", S_RD, 32'h1000);
`endif
        step(); csr(2'b01, MIE, 32'h000C_0000, 1'b0);
        step(); csr(2'b10, MSTATUS, 32'h8, 1'b0); expect_val("mstatus_pre2", S_RD, 32'h1880);
        step(); irq_local = 4'b1100; expect_val("local_latency", S_TRAP, 32'd0);
        step();
        expect_val("local_trap", S_TRAP, 32'd1);
`ifdef CSR_VECTORED_MODE_EN
        expect_val("local_rpc", S_RPC, 32'h1048);
`else
        expect_val("local_rpc", S_RPC, 32'h1000);
`endif
        step(); irq_local = 4'h0; rd(MCAUSE); expect_val("local_mcause", S_RD, 32'h8000_0012);

        // Asynchronous reset mid-operation
        step(); irq_ext = 1'b1;
        step(); reset_n = 1'b0; rd(MCYCLE); expect_val("arst_mcycle", S_RD, 32'h0);
        step(); rd(MIP); expect_val("arst_mip", S_RD, 32'h0);
        step(); reset_n = 1'b1; irq_ext = 1'b0; rd(MTVEC); expect_val("arst_mtvec", S_RD, MTV_RST);
        step(); rd(MSCRATCH); expect_val("arst_mscratch", S_RD, 32'h0);

        step(); step();
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
            n_err = n_err + sb_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
